uart_tx_queue: RTL and testbench

Byte queue that sits directly upstream of the UART transmitter. It buffers bytes written by the host logic in bursts and feeds them one at a time over the transmitter's start/data/busy handshake, so producers never have to poll `TxD_busy`. It also reports fill level and overflow.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 35 +++
 rtl/uart_tx_queue.sv | 125 ++++++++++++
 tb/tb_uart_tx_queue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_q_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte register array: synchronous write, asynchronous read so the
// head byte is available combinationally for the load into TxD_data.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register; contents are don't-care after reset, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter over its start/data/busy handshake,
// with fill level and sticky overflow reporting.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [LW-1:0]          level,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   TxD_start,
    output logic [UART_DATA_W-1:0] TxD_data,
    input  logic                   TxD_busy
);

    localparam int AW = $clog2(DEPTH);

    tx_q_state_t            state_q, state_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic                   start_q, start_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic [UART_DATA_W-1:0] head_data;
    logic                   wr_accept;
    logic                   pop;

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    // Flags come from the registered level only, so wr_en never reaches an output.
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign TxD_start = start_q;
    assign TxD_data  = data_q;

    // Next-state logic: handshake FSM, pointers, level and overflow flag.
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        data_d     = data_q;

        wr_accept  = wr_en & ~full;
        pop        = (state_q == IDLE) & ~empty & ~TxD_busy;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (TxD_busy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!TxD_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            data_d   = head_data;
        end

        case ({wr_accept, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A dropped write outranks a same-cycle clear.
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (wr_en & full) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            start_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            start_q    <= start_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a behavioural transmitter model.
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          full, empty, overflow;
    logic [LW-1:0] level;
    logic          ovf_clr = 1'b0;
    logic          TxD_start;
    logic [7:0]    TxD_data;
    logic          TxD_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .TxD_start (TxD_start),
        .TxD_data  (TxD_data),
        .TxD_busy  (TxD_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy rises the cycle after a start, lasts busy_len cycles.
    int         busy_len   = 20;
    bit         force_busy = 1'b0;
    int         cnt        = 0;
    bit         pend       = 1'b0;
    int         neg_cnt    = 0;
    int         fall_neg   = -1;
    bit         gap_chk    = 1'b0;
    int         start_cnt  = 0;
    int         max_level  = 0;
    bit         prev_start = 1'b0;
    bit         prev_busy  = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        bit busy_now;
        neg_cnt++;
        if (int'(level) > max_level) max_level = int'(level);
        if (TxD_start && !prev_start) begin
            start_cnt++;
            got_q.push_back(TxD_data);
            chk("start_while_busy", TxD_busy, 0);
            if (gap_chk && fall_neg >= 0) chk("start_gap", neg_cnt - fall_neg, 2);
        end
        prev_start = TxD_start;
        if (pend) begin
            cnt  = busy_len;
            pend = 1'b0;
        end else if (cnt > 0) begin
            cnt--;
        end
        if (TxD_start) pend = 1'b1;
        busy_now = force_busy || (cnt > 0);
        if (prev_busy && !busy_now) fall_neg = neg_cnt;
        TxD_busy  = busy_now;
        prev_busy = busy_now;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_drain(string name, int bound);
        int i = 0;
        while (!(empty && !TxD_busy && !pend && !TxD_start) && i < bound) begin
            tick(1);
            i++;
        end
        chk(name, (i < bound), 1);
        tick(4);
    endtask

    task automatic chk_seq(string name, logic [7:0] exp_q[$]);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(name, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
        end
    endtask

    typedef struct {
        bit wr;
        bit clr;
        int reps;
        int lvl;
        bit fl;
        bit ovf;
    } vec_t;

    initial begin
        vec_t       tbl[7];
        logic [7:0] exp_q[$];

        tbl[0] = '{1, 0, 15, 15, 0, 0};
        tbl[1] = '{1, 0, 1,  16, 1, 0};
        tbl[2] = '{1, 0, 2,  16, 1, 1};
        tbl[3] = '{0, 1, 1,  16, 1, 0};
        tbl[4] = '{1, 1, 1,  16, 1, 1};
        tbl[5] = '{0, 1, 1,  16, 1, 0};
        tbl[6] = '{0, 0, 3,  16, 1, 0};

        // Reset defaults
        tick(1);
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_start", TxD_start, 0);
        chk("rst_data", TxD_data, 0);

        // Table: transmitter held busy, so nothing pops
        force_busy = 1'b1;
        tick(1);
        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].reps; r++) begin
                wr_en   = tbl[k].wr;
                wr_data = 8'($urandom);
                ovf_clr = tbl[k].clr;
                tick(1);
            end
            chk("tbl_level", level, tbl[k].lvl);
            chk("tbl_full", full, tbl[k].fl);
            chk("tbl_empty", empty, (tbl[k].lvl == 0));
            chk("tbl_overflow", overflow, tbl[k].ovf);
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        do_reset();
        chk("tbl_rst_level", level, 0);
        force_busy = 1'b0;
        tick(10);
        chk("tbl_no_start_after_rst", start_cnt, 0);

        // Single byte
        got_q.delete();
        start_cnt = 0;
        busy_len  = 100;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick(1);
        wr_en = 1'b0;
        chk("single_level_after_wr", level, 1);
        chk("single_start_early", TxD_start, 0);
        tick(1);
        chk("single_start", TxD_start, 1);
        chk("single_data", TxD_data, 8'hA5);
        chk("single_level_popped", level, 0);
        tick(1);
        chk("single_start_1cyc", TxD_start, 0);
        wait_drain("single_drain", 400);
        exp_q = '{8'hA5};
        chk_seq("single_seq", exp_q);

        // Burst of 5
        got_q.delete();
        start_cnt = 0;
        fall_neg  = -1;
        gap_chk   = 1'b1;
        busy_len  = 12;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick(1);
        end
        wr_en = 1'b0;
        wait_drain("burst_drain", 500);
        gap_chk = 1'b0;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk_seq("burst_seq", exp_q);

        // Fill and overflow
        got_q.delete();
        start_cnt = 0;
        max_level = 0;
        busy_len  = 30;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick(1);
        end
        wr_en = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_level", level, DEPTH);
        chk("fill_overflow", overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("fill_ovf_clr", overflow, 0);
        wait_drain("fill_drain", 2000);
        chk("fill_max_level", max_level, DEPTH);
        exp_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(8'(8'h40 + i));
        chk_seq("fill_seq", exp_q);

        // Wrap-around with random gaps and busy lengths
        got_q.delete();
        exp_q.delete();
        max_level = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            int w = 0;
            tick($urandom_range(0, 3));
            while (full && w < 1000) begin
                tick(1);
                w++;
            end
            if (w >= 1000) chk("wrap_full_timeout", full, 0);
            busy_len = $urandom_range(1, 20);
            wr_en = 1'b1; wr_data = 8'(i);
            exp_q.push_back(8'(i));
            tick(1);
            wr_en = 1'b0;
        end
        wait_drain("wrap_drain", 3000);
        chk("wrap_max_level", (max_level <= DEPTH), 1);
        chk("wrap_overflow", overflow, 0);
        chk_seq("wrap_seq", exp_q);

        // Reset mid-operation (FSM in WAIT_DONE, 4 bytes queued)
        got_q.delete();
        start_cnt = 0;
        busy_len  = 40;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h90 + i);
            tick(1);
        end
        wr_en = 1'b0;
        tick(8);
        chk("mid_level_before", level, 4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_empty", empty, 1);
        chk("mid_level", level, 0);
        chk("mid_start", TxD_start, 0);
        chk("mid_data", TxD_data, 0);
        wait_drain("mid_drain", 300);
        chk("mid_no_more_starts", start_cnt, 1);
        busy_len = 10;
        wr_en = 1'b1; wr_data = 8'h3C;
        tick(1);
        wr_en = 1'b0;
        wait_drain("mid_post_drain", 300);
        exp_q = '{8'h90, 8'h3C};
        chk_seq("mid_seq", exp_q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
